uart_tx: RTL and testbench



---
 rtl/uart_tx.sv | 184 ++++++++++++++++++
 tb/tb_uart_tx.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
//
// Serial transmitter that drains a byte FIFO. While idle it pops the FIFO
// front as soon as the FIFO reports non-empty. The popped byte is latched in
// the same cycle, so later changes on fifo_data cannot corrupt the frame in
// flight. The byte is then sent as start bit, 8 data bits LSB first, an
// optional parity bit, and one or two stop bits.
//
// Parameters:
//   CLK_FREQ     - system clock in Hz
//   BAUD         - line rate in bit/s
//   CLKS_PER_BIT - clock cycles per bit (>= 2)
//   PARITY       - 0 none, 1 even, 2 odd
//   STOP_BITS    - 1 or 2
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous active-high reset
//   fifo_empty - FIFO empty flag
//   fifo_data  - FIFO front byte, valid while fifo_empty is low
//   fifo_pop   - FIFO pop strobe (combinational)
//   tx         - serial line, idle high (registered)
//   busy       - frame in progress (registered)
// ---------------------------------------------------------------------------
module uart_tx #(
    parameter int CLK_FREQ     = 12000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_pop,
    output logic       tx,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t           state_q,   state_d;
    logic [CNT_W-1:0] baudCnt_q, baudCnt_d;
    logic [2:0]       bitIdx_q,  bitIdx_d;
    logic [7:0]       shift_q,   shift_d;
    logic             parity_q,  parity_d;
    logic             tx_q,      tx_d;
    logic             busy_q,    busy_d;

    // State register. The line outputs are registered too, so tx and busy
    // always reflect the state that is currently in force.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            baudCnt_q <= '0;
            bitIdx_q  <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            baudCnt_q <= baudCnt_d;
            bitIdx_q  <= bitIdx_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state logic. The baud counter restarts at every bit boundary, so
    // one bit time is always exactly CLKS_PER_BIT cycles. In the stop phase
    // bitIdx counts the stop bits instead of data bits.
    always_comb begin
        state_d   = state_q;
        baudCnt_d = baudCnt_q;
        bitIdx_d  = bitIdx_q;
        shift_d   = shift_q;
        parity_d  = parity_q;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d   = ST_START;
                    shift_d   = fifo_data;
                    parity_d  = 1'b0;
                    baudCnt_d = '0;
                    bitIdx_d  = '0;
                end
            end

            ST_START: begin
                if (baudCnt_q == CNT_LAST) begin
                    state_d   = ST_DATA;
                    baudCnt_d = '0;
                    bitIdx_d  = '0;
                end else begin
                    baudCnt_d = baudCnt_q + CNT_W'(1);
                end
            end

            // The bit on the line is shift_q[0]. It is folded into the
            // parity accumulator as it leaves the shifter.
            ST_DATA: begin
                if (baudCnt_q == CNT_LAST) begin
                    baudCnt_d = '0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    parity_d  = parity_q ^ shift_q[0];
                    if (bitIdx_q == 3'd7) begin
                        bitIdx_d = '0;
                        state_d  = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end else begin
                    baudCnt_d = baudCnt_q + CNT_W'(1);
                end
            end

            ST_PARITY: begin
                if (baudCnt_q == CNT_LAST) begin
                    state_d   = ST_STOP;
                    baudCnt_d = '0;
                    bitIdx_d  = '0;
                end else begin
                    baudCnt_d = baudCnt_q + CNT_W'(1);
                end
            end

            ST_STOP: begin
                if (baudCnt_q == CNT_LAST) begin
                    baudCnt_d = '0;
                    if (bitIdx_q == STOP_LAST) begin
                        state_d  = ST_IDLE;
                        bitIdx_d = '0;
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end else begin
                    baudCnt_d = baudCnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d   = ST_IDLE;
                baudCnt_d = '0;
                bitIdx_d  = '0;
            end
        endcase
    end

    // Output logic. tx and busy are computed from the next state so that,
    // once registered, they line up with the state in the following cycle.
    // The pop is gated by rst so that nothing leaves the FIFO while the
    // transmitter is held in reset.
    always_comb begin
        fifo_pop = (state_q == ST_IDLE) && !fifo_empty && !rst;
        busy_d   = (state_d != ST_IDLE);

        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = (PARITY == 2) ? ~parity_d : parity_d;
            default:   tx_d = 1'b1;
        endcase
    end

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
//
// Directed bench for uart_tx. dutA uses the default 8N1 configuration.
// dutB uses odd parity and two stop bits. Line traces are recorded one
// sample per cycle, with cycle 0 being the pop cycle of the step. Bit
// centres are then read back at 1+52+k*104.
// ---------------------------------------------------------------------------
module tb_uart_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       emptyA, emptyB;
    logic [7:0] dataA,  dataB;
    logic       popA,   popB;
    logic       txA,    txB;
    logic       busyA,  busyB;

    int compared   = 0;
    int mismatched = 0;

    logic       traceTxA   [0:3999];
    logic       traceBusyA [0:3999];
    logic       traceTxB   [0:1299];
    logic       traceBusyB [0:1299];
    int         popCycA[$];
    logic [7:0] fifoQA[$];
    int         popCountA = 0;
    int         popsB     = 0;
    logic       prevPopA  = 1'b0;
    logic       prevPopB  = 1'b0;
    logic       sawTxLow  = 1'b0;
    logic       sawBusy   = 1'b0;
    logic       sawPop    = 1'b0;
    logic [9:0] exp55     = 10'b1010101010;
    logic [7:0] expBytes [0:2];
    logic [7:0] byteB;
    int         basePops;

    uart_tx dutA (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (emptyA),
        .fifo_data  (dataA),
        .fifo_pop   (popA),
        .tx         (txA),
        .busy       (busyA)
    );

    uart_tx #(
        .PARITY    (2),
        .STOP_BITS (2)
    ) dutB (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (emptyB),
        .fifo_data  (dataB),
        .fifo_pop   (popB),
        .tx         (txB),
        .busy       (busyB)
    );

    // Single comparison point: counts, and reports on a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drives dutA from a FIFO model for a fixed number of cycles. The model
    // drops its front at the edge that closes a pop cycle, and the new front
    // appears one cycle later.
    task automatic applyStimulus(input int cycles);
        logic popped;
        popCycA.delete();
        emptyA = (fifoQA.size() == 0);
        dataA  = emptyA ? 8'h00 : fifoQA[0];
        for (int c = 0; c < cycles; c++) begin
            #2;
            traceTxA[c]   = txA;
            traceBusyA[c] = busyA;
            popped        = popA;
            if (popA) popCycA.push_back(c);
            @(posedge clk);
            #1;
            if (popped && fifoQA.size() > 0) void'(fifoQA.pop_front());
            emptyA = (fifoQA.size() == 0);
            dataA  = emptyA ? 8'h00 : fifoQA[0];
        end
    endtask

    function automatic logic [7:0] decodeA(input int p);
        logic [7:0] b;
        for (int k = 0; k < 8; k++) b[k] = traceTxA[p + 53 + (k + 1) * 104];
        return b;
    endfunction

    // FIFO read contract, checked every cycle on both instances.
    always @(negedge clk) begin
        checkOutput("popOnEmptyA", {31'b0, popA & emptyA}, 32'd0);
        checkOutput("popBackToBackA", {31'b0, popA & prevPopA}, 32'd0);
        checkOutput("popOnEmptyB", {31'b0, popB & emptyB}, 32'd0);
        checkOutput("popBackToBackB", {31'b0, popB & prevPopB}, 32'd0);
        prevPopA <= popA;
        prevPopB <= popB;
        if (popA) popCountA <= popCountA + 1;
    end

    initial begin
        expBytes[0] = 8'h00;
        expBytes[1] = 8'hFF;
        expBytes[2] = 8'hA3;

        // Reset with a non-empty FIFO: the pop must stay forced low.
        rst    = 1'b1;
        emptyA = 1'b0;
        dataA  = 8'hAA;
        emptyB = 1'b1;
        dataB  = 8'h00;
        @(posedge clk);
        #3;
        checkOutput("rstPop", {31'b0, popA}, 32'd0);
        checkOutput("rstTx", {31'b0, txA}, 32'd1);
        checkOutput("rstBusy", {31'b0, busyA}, 32'd0);
        checkOutput("rstTxB", {31'b0, txB}, 32'd1);
        @(posedge clk);
        #1;
        emptyA = 1'b1;
        rst    = 1'b0;

        // Long idle with an empty FIFO.
        repeat (2000) begin
            #2;
            if (txA !== 1'b1 || txB !== 1'b1) sawTxLow = 1'b1;
            if (busyA !== 1'b0 || busyB !== 1'b0) sawBusy = 1'b1;
            if (popA !== 1'b0 || popB !== 1'b0) sawPop = 1'b1;
            @(posedge clk);
            #1;
        end
        checkOutput("idleTxLow", {31'b0, sawTxLow}, 32'd0);
        checkOutput("idleBusy", {31'b0, sawBusy}, 32'd0);
        checkOutput("idlePop", {31'b0, sawPop}, 32'd0);

        // Single byte 0x55 at defaults.
        fifoQA = {8'h55};
        applyStimulus(1045);
        checkOutput("pops55", popCycA.size(), 32'd1);
        if (popCycA.size() > 0) checkOutput("popCycle55", popCycA[0], 32'd0);
        for (int k = 0; k < 10; k++)
            checkOutput($sformatf("bit55_%0d", k), {31'b0, traceTxA[53 + k * 104]},
                        {31'b0, exp55[k]});
        checkOutput("busy55_c0", {31'b0, traceBusyA[0]}, 32'd0);
        checkOutput("busy55_c1", {31'b0, traceBusyA[1]}, 32'd1);
        checkOutput("busy55_c1040", {31'b0, traceBusyA[1040]}, 32'd1);
        checkOutput("busy55_c1041", {31'b0, traceBusyA[1041]}, 32'd0);
        checkOutput("tx55_c1041", {31'b0, traceTxA[1041]}, 32'd1);

        // Three back-to-back bytes.
        fifoQA = {8'h00, 8'hFF, 8'hA3};
        applyStimulus(3140);
        checkOutput("pops3", popCycA.size(), 32'd3);
        if (popCycA.size() == 3) begin
            checkOutput("popGap01", popCycA[1] - popCycA[0], 32'd1041);
            checkOutput("popGap12", popCycA[2] - popCycA[1], 32'd1041);
            for (int f = 0; f < 3; f++) begin
                checkOutput($sformatf("byte3_%0d", f), {24'b0, decodeA(popCycA[f])},
                            {24'b0, expBytes[f]});
                checkOutput($sformatf("start3_%0d", f),
                            {31'b0, traceTxA[popCycA[f] + 53]}, 32'd0);
                checkOutput($sformatf("stop3_%0d", f),
                            {31'b0, traceTxA[popCycA[f] + 53 + 936]}, 32'd1);
            end
            checkOutput("gapIdle", {31'b0, traceTxA[popCycA[0] + 1041]}, 32'd1);
            checkOutput("gapNextStart", {31'b0, traceTxA[popCycA[0] + 1042]}, 32'd0);
        end

        // Odd parity, two stop bits, byte 0x07 on dutB.
        emptyB = 1'b0;
        dataB  = 8'h07;
        for (int c = 0; c < 1260; c++) begin
            #2;
            traceTxB[c]   = txB;
            traceBusyB[c] = busyB;
            if (popB) popsB++;
            @(posedge clk);
            #1;
            emptyB = 1'b1;
            dataB  = 8'hFF;
        end
        for (int k = 0; k < 8; k++) byteB[k] = traceTxB[53 + (k + 1) * 104];
        checkOutput("popsB", popsB, 32'd1);
        checkOutput("startB", {31'b0, traceTxB[53]}, 32'd0);
        checkOutput("byteB", {24'b0, byteB}, 32'h07);
        checkOutput("parityB", {31'b0, traceTxB[989]}, 32'd0);
        checkOutput("parityEndB", {31'b0, traceTxB[1040]}, 32'd0);
        checkOutput("stopFirstB", {31'b0, traceTxB[1041]}, 32'd1);
        checkOutput("stopLastB", {31'b0, traceTxB[1248]}, 32'd1);
        checkOutput("busyLastB", {31'b0, traceBusyB[1248]}, 32'd1);
        checkOutput("busyEndB", {31'b0, traceBusyB[1249]}, 32'd0);

        // Reset in the middle of data bit 3 of 0x81.
        basePops = popCountA;
        fifoQA   = {8'h81};
        applyStimulus(470);
        checkOutput("pops81", popCycA.size(), 32'd1);
        rst = 1'b1;
        #2;
        checkOutput("preRstTx", {31'b0, txA}, 32'd0);
        checkOutput("preRstBusy", {31'b0, busyA}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        checkOutput("postRstTx", {31'b0, txA}, 32'd1);
        checkOutput("postRstBusy", {31'b0, busyA}, 32'd0);
        checkOutput("postRstPop", {31'b0, popA}, 32'd0);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        emptyA = 1'b0;
        dataA  = 8'h3C;
        #2;
        checkOutput("rstIdlePop", {31'b0, popA}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("noRepop", popCountA - basePops, 32'd1);
        fifoQA = {8'h3C};
        applyStimulus(1045);
        checkOutput("popsAfterRst", popCycA.size(), 32'd1);
        if (popCycA.size() > 0) checkOutput("popCycleAfterRst", popCycA[0], 32'd0);
        checkOutput("busyAfterRst_c0", {31'b0, traceBusyA[0]}, 32'd0);
        checkOutput("startAfterRst", {31'b0, traceTxA[53]}, 32'd0);
        checkOutput("byteAfterRst", {24'b0, decodeA(0)}, 32'h3C);
        checkOutput("stopAfterRst", {31'b0, traceTxA[989]}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
